// File: rtl/tinyqv_gpio_irq.sv
// GPIO outputs with atomic set/clear/toggle, synchronised inputs and per-pin edge/level interrupts.
// Optional input debounce filter built when GPIO_DEBOUNCE_EN is defined.
module tinyqv_gpio_irq #(
  parameter int          NUM_OUT         = 8,
  parameter int          NUM_IN          = 4,
  parameter logic [27:0] BASE_ADDR       = 28'h8000000,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [27:0]       addr,
  input  logic [1:0]        write_n,
  input  logic [1:0]        read_n,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              hit,
  output logic              data_ready,
  input  logic [NUM_IN-1:0] gpio_in,
  output logic [NUM_OUT-1:0] gpio_out,
  output logic              irq,
  output logic [NUM_IN-1:0] irq_vec
);

  localparam int MODE_W = 2 * NUM_IN;

  typedef enum logic [2:0] {
    REG_OUT  = 3'd0,
    REG_IN   = 3'd1,
    REG_SET  = 3'd2,
    REG_CLR  = 3'd3,
    REG_TGL  = 3'd4,
    REG_EN   = 3'd5,
    REG_PEND = 3'd6,
    REG_MODE = 3'd7
  } regSel_e;

  logic [NUM_OUT-1:0] out_q, out_d;
  logic [NUM_IN-1:0]  en_q, en_d;
  logic [NUM_IN-1:0]  pend_q, pend_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [NUM_IN-1:0]  prev_q;
  logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync_q;

  logic [NUM_IN-1:0] syncRaw, filt;
  logic [NUM_IN-1:0] levelSet, edgeSet, w1c;
  logic [31:0]       wrMask, wrData, rdData;
  logic              wrEn;
  regSel_e           regSel;
  logic              unused_ok;

  assign hit        = (addr[27:5] == BASE_ADDR[27:5]);
  assign regSel     = regSel_e'(addr[4:2]);
  assign wrEn       = hit && (write_n != 2'b11);
  assign wrData     = data_in & wrMask;
  assign data_ready = 1'b1;
  assign unused_ok  = &{1'b0, addr[1:0], read_n};

  always_comb begin
    case (write_n)
      2'b00:   wrMask = 32'h0000_00FF;
      2'b01:   wrMask = 32'h0000_FFFF;
      2'b10:   wrMask = 32'hFFFF_FFFF;
      default: wrMask = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign syncRaw = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_IN-1:0] filt_q;
  logic [CNT_W-1:0]  cnt_q [NUM_IN];

  // Counter tracks consecutive cycles where the raw input disagrees with the filtered value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (syncRaw[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i] <= syncRaw[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = syncRaw;
`endif

  always_comb begin
    levelSet = '0;
    edgeSet  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      case (mode_q[2*i +: 2])
        2'b00:   levelSet[i] = filt[i];
        2'b01:   edgeSet[i]  = filt[i] & ~prev_q[i];
        2'b10:   edgeSet[i]  = ~filt[i] & prev_q[i];
        default: edgeSet[i]  = filt[i] ^ prev_q[i];
      endcase
    end
  end

  always_comb begin
    out_d  = out_q;
    en_d   = en_q;
    mode_d = mode_q;
    w1c    = '0;
    if (wrEn) begin
      case (regSel)
        REG_OUT:  out_d  = NUM_OUT'((32'(out_q) & ~wrMask) | wrData);
        REG_SET:  out_d  = out_q | NUM_OUT'(wrData);
        REG_CLR:  out_d  = out_q & ~NUM_OUT'(wrData);
        REG_TGL:  out_d  = out_q ^ NUM_OUT'(wrData);
        REG_EN:   en_d   = NUM_IN'((32'(en_q) & ~wrMask) | wrData);
        REG_PEND: w1c    = NUM_IN'(wrData);
        REG_MODE: mode_d = MODE_W'((32'(mode_q) & ~wrMask) | wrData);
        default:  ;
      endcase
    end
  end

  // Edge events beat a same-cycle clear; a level request is held off for the clear cycle so
  // software sees the bit drop for one cycle before a still-high pin re-asserts it.
  assign pend_d = (pend_q & ~w1c) | (edgeSet & en_q) | (levelSet & en_q & ~w1c);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      en_q   <= '0;
      pend_q <= '0;
      mode_q <= '0;
      prev_q <= '0;
    end else begin
      out_q  <= out_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
      prev_q <= filt;
    end
  end

  always_comb begin
    case (regSel)
      REG_OUT:  rdData = 32'(out_q);
      REG_IN:   rdData = 32'(filt);
      REG_EN:   rdData = 32'(en_q);
      REG_PEND: rdData = 32'(pend_q);
      REG_MODE: rdData = 32'(mode_q);
      default:  rdData = 32'h0;
    endcase
  end

  assign data_out = hit ? rdData : 32'h0;
  assign gpio_out = out_q;
  assign irq_vec  = pend_q & en_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_tinyqv_gpio_irq.sv
// Scoreboard bench for tinyqv_gpio_irq: stimulus queues expected values, a negedge monitor
// pops and compares whenever a read or probe is presented.
module tb_tinyqv_gpio_irq;

  localparam int          NUM_OUT = 32;
  localparam int          NUM_IN  = 4;
  localparam int          DEB     = 4;
  localparam logic [27:0] BASE    = 28'h8000000;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = DEB;
`else
  localparam int LAT = 0;
`endif

  localparam logic [4:0] A_OUT = 5'h00, A_IN = 5'h04, A_SET = 5'h08, A_CLR = 5'h0C,
                         A_TGL = 5'h10, A_EN = 5'h14, A_PEND = 5'h18, A_MODE = 5'h1C;
  localparam logic [1:0] W_BYTE = 2'b00, W_HALF = 2'b01, W_WORD = 2'b10, W_IDLE = 2'b11;

  localparam int SEL_DATA = 0, SEL_GPIO = 1, SEL_IRQ = 2, SEL_VEC = 3, SEL_HIT = 4;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [27:0]        addr = BASE;
  logic [1:0]         write_n = W_IDLE;
  logic [1:0]         read_n = W_IDLE;
  logic [31:0]        data_in = '0;
  logic [31:0]        data_out;
  logic               hit;
  logic               data_ready;
  logic [NUM_IN-1:0]  gpio_in = '0;
  logic [NUM_OUT-1:0] gpio_out;
  logic               irq;
  logic [NUM_IN-1:0]  irq_vec;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } expItem_t;

  expItem_t sbq[$];
  int       testsRun = 0;
  int       testsFailed = 0;
  logic     probe = 1'b0;

  tinyqv_gpio_irq #(
    .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .BASE_ADDR(BASE),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .write_n(write_n), .read_n(read_n),
    .data_in(data_in), .data_out(data_out), .hit(hit), .data_ready(data_ready),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    expItem_t    e;
    logic [31:0] act;
    if (data_ready && (read_n != W_IDLE || probe)) begin
      testsRun++;
      if (sbq.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_output: got an output with no expected value queued");
      end else begin
        e = sbq.pop_front();
        case (e.sel)
          SEL_DATA: act = data_out;
          SEL_GPIO: act = 32'(gpio_out);
          SEL_IRQ:  act = {31'b0, irq};
          SEL_VEC:  act = 32'(irq_vec);
          default:  act = {31'b0, hit};
        endcase
        if (act !== e.exp) begin
          testsFailed++;
          $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] off, input logic [1:0] wn, input logic [31:0] d);
    addr    = BASE + 28'(off);
    write_n = wn;
    data_in = d;
    @(posedge clk);
    #1;
    write_n = W_IDLE;
  endtask

  task automatic checkReadAddr(input string name, input logic [27:0] a, input logic [31:0] exp);
    addr   = a;
    read_n = W_WORD;
    sbq.push_back('{name: name, sel: SEL_DATA, exp: exp});
    @(posedge clk);
    #1;
    read_n = W_IDLE;
  endtask

  task automatic checkRead(input string name, input logic [4:0] off, input logic [31:0] exp);
    checkReadAddr(name, BASE + 28'(off), exp);
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    sbq.push_back('{name: name, sel: sel, exp: exp});
    probe = 1'b1;
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle(2);
    rstn = 1'b1;
    idle(1);

    checkOutput("rst_gpio_out", SEL_GPIO, 32'h0);
    checkOutput("rst_irq", SEL_IRQ, 32'h0);
    checkRead("rst_out", A_OUT, 32'h0);

    // Atomic output operations
    applyStimulus(A_OUT, W_WORD, 32'h0000_00A5);
    checkOutput("out_wr", SEL_GPIO, 32'h0000_00A5);
    applyStimulus(A_SET, W_WORD, 32'h0000_000F);
    checkOutput("out_set", SEL_GPIO, 32'h0000_00AF);
    applyStimulus(A_CLR, W_WORD, 32'h0000_0081);
    checkOutput("out_clr", SEL_GPIO, 32'h0000_002E);
    applyStimulus(A_TGL, W_WORD, 32'h0000_00FF);
    checkOutput("out_tgl", SEL_GPIO, 32'h0000_00D1);
    checkRead("set_reads_zero", A_SET, 32'h0);

    // Partial-width writes
    applyStimulus(A_OUT, W_WORD, 32'h1234_5678);
    checkRead("out_word", A_OUT, 32'h1234_5678);
    applyStimulus(A_OUT, W_BYTE, 32'hAABB_CCFF);
    checkRead("out_byte", A_OUT, 32'h1234_56FF);
    applyStimulus(A_OUT, W_HALF, 32'hDEAD_BEEF);
    checkRead("out_half", A_OUT, 32'h1234_BEEF);
    applyStimulus(A_SET, W_BYTE, 32'hFFFF_FF00);
    checkOutput("set_byte_upper_ignored", SEL_GPIO, 32'h1234_BEEF);

    // Bits beyond NUM_IN are dropped
    applyStimulus(A_EN, W_WORD, 32'hFFFF_FFFF);
    checkRead("en_width", A_EN, 32'h0000_000F);
    applyStimulus(A_EN, W_WORD, 32'h0);
    applyStimulus(A_MODE, W_WORD, 32'hFFFF_FFFF);
    checkRead("mode_width", A_MODE, 32'h0000_00FF);
    applyStimulus(A_MODE, W_WORD, 32'h0000_0001);
    checkRead("mode_rd", A_MODE, 32'h0000_0001);

    addr = 28'h0000100;
    checkOutput("miss_hit", SEL_HIT, 32'h0);
    checkReadAddr("miss_data", 28'h0000118, 32'h0);

    // Rising edge on pin 0
    applyStimulus(A_EN, W_WORD, 32'h1);
    gpio_in = 4'b0001;
    for (int i = 0; i < 3 + LAT; i++) checkOutput("rise_irq_early", SEL_IRQ, 32'h0);
    checkOutput("rise_irq", SEL_IRQ, 32'h1);
    applyStimulus(A_PEND, W_WORD, 32'h1);
    checkOutput("rise_w1c_irq", SEL_IRQ, 32'h0);
    checkOutput("rise_held_irq", SEL_IRQ, 32'h0);
    checkRead("rise_pend", A_PEND, 32'h0);

    // Level mode on pin 1
    applyStimulus(A_EN, W_WORD, 32'h2);
    gpio_in = 4'b0011;
    idle(4 + LAT);
    checkOutput("level_vec", SEL_VEC, 32'h2);
    checkRead("level_pend", A_PEND, 32'h2);
    applyStimulus(A_PEND, W_WORD, 32'h2);
    checkOutput("level_cleared", SEL_VEC, 32'h0);
    checkOutput("level_reassert", SEL_VEC, 32'h2);

    applyStimulus(A_EN, W_WORD, 32'h0);
    checkRead("en_off_keeps_pend", A_PEND, 32'h2);
    checkOutput("en_off_irq", SEL_IRQ, 32'h0);
    applyStimulus(A_PEND, W_WORD, 32'h2);
    gpio_in = 4'b0001;
    idle(4 + LAT);
    gpio_in = 4'b0011;
    idle(4 + LAT);
    checkRead("en_off_no_pend", A_PEND, 32'h0);

    // Reset in the middle of a write
    applyStimulus(A_EN, W_WORD, 32'h2);
    applyStimulus(A_OUT, W_WORD, 32'h0000_00FF);
    checkOutput("pre_rst_irq", SEL_IRQ, 32'h1);
    addr    = BASE + 28'(A_OUT);
    write_n = W_WORD;
    data_in = 32'h0000_0055;
    #2;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    write_n = W_IDLE;
    checkOutput("rstmid_gpio_out", SEL_GPIO, 32'h0);
    checkOutput("rstmid_irq", SEL_IRQ, 32'h0);
    checkRead("rstmid_out", A_OUT, 32'h0);
    checkRead("rstmid_pend", A_PEND, 32'h0);
    checkRead("rstmid_en", A_EN, 32'h0);
    checkRead("rstmid_mode", A_MODE, 32'h0);
    checkRead("rstmid_in", A_IN, 32'h0);
    rstn = 1'b1;
    idle(4 + LAT);
    checkRead("post_rst_pend", A_PEND, 32'h0);
    checkRead("post_rst_in", A_IN, 32'h3);
    checkOutput("post_rst_irq", SEL_IRQ, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    applyStimulus(A_MODE, W_WORD, 32'h0000_0010);
    applyStimulus(A_EN, W_WORD, 32'h4);
    gpio_in = 4'b0111;
    idle(3);
    gpio_in = 4'b0011;
    idle(10);
    checkRead("glitch_in", A_IN, 32'h3);
    checkRead("glitch_pend", A_PEND, 32'h0);
    gpio_in = 4'b0111;
    idle(5);
    checkRead("pulse_in_early", A_IN, 32'h3);
    gpio_in = 4'b0011;
    checkRead("pulse_in_high", A_IN, 32'h7);
    checkRead("pulse_pend", A_PEND, 32'h4);
    idle(12);
    checkRead("pulse_in_low", A_IN, 32'h3);
`endif

    idle(2);
    testsRun++;
    if (sbq.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d unchecked entries, expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
